// File: rtl/wb_interconnect_n_if.sv
// Wishbone bundle between the Caravel-side master and the N slave ports of wb_interconnect_n.
// The slave modport is the interconnect's view; master is the surrounding environment's view.
interface wb_interconnect_n_if #(
  parameter int NUM_SLAVES = 4
);
  logic                    wbs_cyc_i;
  logic                    wbs_stb_i;
  logic                    wbs_we_i;
  logic [3:0]              wbs_sel_i;
  logic [31:0]             wbs_adr_i;
  logic [31:0]             wbs_dat_i;
  logic                    wbs_ack_o;
  logic                    wbs_err_o;
  logic [31:0]             wbs_dat_o;

  logic [NUM_SLAVES-1:0]    wbm_cyc_o;
  logic [NUM_SLAVES-1:0]    wbm_stb_o;
  logic [NUM_SLAVES-1:0]    wbm_we_o;
  logic [4*NUM_SLAVES-1:0]  wbm_sel_o;
  logic [32*NUM_SLAVES-1:0] wbm_adr_o;
  logic [32*NUM_SLAVES-1:0] wbm_dat_o;
  logic [NUM_SLAVES-1:0]    wbm_ack_i;
  logic [32*NUM_SLAVES-1:0] wbm_dat_i;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_err_o, wbs_dat_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_err_o, wbs_dat_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i
  );
endinterface

// File: rtl/wb_interconnect_n.sv
// Wishbone 1:N interconnect: registered request, windowed decode, timeout and unmapped error termination.
// Define WBMUX_ERR_CAPTURE_EN to add sticky err_addr_o / err_cause_o fault capture outputs.
module wb_interconnect_n #(
  parameter int                       NUM_SLAVES     = 4,
  parameter logic [32*NUM_SLAVES-1:0] BASE_ADDRS     = {32'h3000_3000, 32'h3000_2000,
                                                        32'h3000_1000, 32'h3000_0000},
  parameter logic [8*NUM_SLAVES-1:0]  ADDR_WIDTHS    = {8'd12, 8'd12, 8'd12, 8'd12},
  parameter int                       TIMEOUT_CYCLES = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  wb_interconnect_n_if.slave   bus,
`ifdef WBMUX_ERR_CAPTURE_EN
  output logic [31:0]          err_addr_o,
  output logic [1:0]           err_cause_o,
`endif
  output logic                 busy_o
);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [31:0]           r_adr;
  logic [31:0]           r_dat;
  logic [31:0]           r_rdata;
  logic [3:0]            r_sel;
  logic                  r_we;
  logic                  r_err;
  logic [NUM_SLAVES-1:0] r_slave;
  logic [15:0]           r_cnt;

  logic                  w_req;
  logic                  w_any_match;
  logic                  w_found;
  logic                  w_sel_ack;
  logic                  w_timeout;
  logic [NUM_SLAVES-1:0] w_match;
  logic [NUM_SLAVES-1:0] w_onehot;
  logic [31:0]           w_sel_rdata;

  assign w_req = bus.wbs_cyc_i & bus.wbs_stb_i;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
      localparam logic [31:0] BASE = BASE_ADDRS[32*gi +: 32];
      localparam int          AW   = int'(ADDR_WIDTHS[8*gi +: 8]);
      // A 32-bit window leaves nothing to compare, so it claims every address.
      if (AW >= 32) begin : g_all
        assign w_match[gi] = 1'b1;
      end else begin : g_win
        assign w_match[gi] = (bus.wbs_adr_i >> AW) == (BASE >> AW);
      end
    end
  endgenerate

  assign w_any_match = |w_match;

  // Overlapping windows resolve to the lowest-numbered slave.
  always_comb begin
    w_onehot = '0;
    w_found  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (w_match[i] && !w_found) begin
        w_onehot[i] = 1'b1;
        w_found     = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_slave[i]) begin
        w_sel_rdata = w_sel_rdata | bus.wbm_dat_i[32*i +: 32];
      end
    end
  end

  assign w_sel_ack = |(bus.wbm_ack_i & r_slave);
  assign w_timeout = (r_cnt == TIMEOUT_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Master abort takes precedence; otherwise a late ack still beats the timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_state_next = w_any_match ? ACTIVE : RESP;
        end
      end
      ACTIVE: begin
        if (!bus.wbs_cyc_i) begin
          w_state_next = IDLE;
        end else if (w_sel_ack || w_timeout) begin
          w_state_next = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_adr   <= '0;
      r_dat   <= '0;
      r_rdata <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_slave <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_req) begin
            r_adr   <= bus.wbs_adr_i;
            r_dat   <= bus.wbs_dat_i;
            r_sel   <= bus.wbs_sel_i;
            r_we    <= bus.wbs_we_i;
            r_slave <= w_onehot;
            r_err   <= ~w_any_match;
            r_rdata <= '0;
          end
        end
        ACTIVE: begin
          r_cnt <= r_cnt + 16'd1;
          if (bus.wbs_cyc_i) begin
            if (w_sel_ack) begin
              r_rdata <= w_sel_rdata;
              r_err   <= 1'b0;
            end else if (w_timeout) begin
              r_err   <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.wbs_ack_o = (r_state == RESP) & ~r_err;
  assign bus.wbs_err_o = (r_state == RESP) &  r_err;
  assign bus.wbs_dat_o = ((r_state == RESP) && !r_err && !r_we) ? r_rdata : 32'd0;
  assign busy_o        = (r_state != IDLE);

  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_port
      assign bus.wbm_cyc_o[gi]         = (r_state == ACTIVE) & r_slave[gi];
      assign bus.wbm_stb_o[gi]         = (r_state == ACTIVE) & r_slave[gi];
      assign bus.wbm_we_o[gi]          = r_we;
      assign bus.wbm_sel_o[4*gi +: 4]  = r_sel;
      assign bus.wbm_adr_o[32*gi +: 32] = r_adr;
      assign bus.wbm_dat_o[32*gi +: 32] = r_dat;
    end
  endgenerate

`ifdef WBMUX_ERR_CAPTURE_EN
  logic [31:0] r_err_addr;
  logic [1:0]  r_err_cause;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_err_addr  <= '0;
      r_err_cause <= '0;
    end else if ((r_state == IDLE) && w_req && !w_any_match) begin
      r_err_addr  <= bus.wbs_adr_i;
      r_err_cause <= 2'b01;
    end else if ((r_state == ACTIVE) && bus.wbs_cyc_i && !w_sel_ack && w_timeout) begin
      r_err_addr  <= r_adr;
      r_err_cause <= 2'b10;
    end
  end

  assign err_addr_o  = r_err_addr;
  assign err_cause_o = r_err_cause;
`endif

endmodule
